// File: rtl/invaders_pkg.sv
// Shared alien-formation types and default march geometry, also used by the sprite renderer.
package invaders_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MARCH  = 2'd1,
    LANDED = 2'd2
  } march_state_t;

  localparam int X_MIN       = 8;
  localparam int X_MAX       = 200;
  localparam int X_STEP      = 8;
  localparam int Y_START     = 32;
  localparam int Y_STEP      = 16;
  localparam int Y_LIMIT     = 400;
  localparam int PERIOD_INIT = 8;

endpackage

// File: rtl/tick_edge_sync.sv
// Synchronises an asynchronous divided-tick level into clk and emits a one-cycle pulse per rising edge.
// Pulse is high in the cycle after the 2nd clk edge that samples the level high; no backpressure.
module tick_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic tick_lvl_i,
  output logic tick_o
);

  // [0],[1] form the synchroniser; [2] is the delay flop for edge detection.
  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], tick_lvl_i};
    end
  end

  assign tick_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/invader_march_ctrl.sv
// Alien-formation march controller: steps, edge drops and landing, advancing once per `period` game ticks.
// Outputs update on the 3rd clk edge after tick_in is sampled high; no backpressure. MARCH_SPEEDUP_EN shortens period on each drop.
import invaders_pkg::*;

module invader_march_ctrl #(
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int P_W         = 4,
  parameter int X_MIN       = invaders_pkg::X_MIN,
  parameter int X_MAX       = invaders_pkg::X_MAX,
  parameter int X_STEP      = invaders_pkg::X_STEP,
  parameter int Y_START     = invaders_pkg::Y_START,
  parameter int Y_STEP      = invaders_pkg::Y_STEP,
  parameter int Y_LIMIT     = invaders_pkg::Y_LIMIT,
  parameter int PERIOD_INIT = invaders_pkg::PERIOD_INIT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick_in,
  input  logic           run,
  input  logic           restart,
  output logic [X_W-1:0] x_pos,
  output logic [Y_W-1:0] y_pos,
  output logic           dir_left,
  output logic           step_pulse,
  output logic           drop_pulse,
  output logic           landed
);

  localparam logic [X_W-1:0] X_MIN_R       = X_W'(X_MIN);
  localparam logic [X_W-1:0] X_STEP_R      = X_W'(X_STEP);
  localparam logic [Y_W-1:0] Y_START_R     = Y_W'(Y_START);
  localparam logic [P_W-1:0] PERIOD_INIT_R = P_W'(PERIOD_INIT);
  // One extra bit so edge and landing comparisons never wrap.
  localparam logic [X_W:0]   X_STEP_E      = (X_W+1)'(X_STEP);
  localparam logic [X_W:0]   X_MAX_E       = (X_W+1)'(X_MAX);
  localparam logic [X_W:0]   X_LEFT_LIM_E  = (X_W+1)'(X_MIN + X_STEP);
  localparam logic [Y_W:0]   Y_STEP_E      = (Y_W+1)'(Y_STEP);
  localparam logic [Y_W:0]   Y_LIMIT_E     = (Y_W+1)'(Y_LIMIT);

  logic tick;

  tick_edge_sync u_tick_sync (
    .clk        (clk),
    .reset      (reset),
    .tick_lvl_i (tick_in),
    .tick_o     (tick)
  );

  march_state_t   state_q;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           dir_q, step_q, drop_q, landed_q;
  logic [P_W-1:0] cnt_q, cnt_inc, period;
  logic [X_W:0]   x_ext;
  logic [Y_W:0]   y_ext;
  logic           step_due, edge_hit, land_hit;

  always_comb begin
    x_ext    = {1'b0, x_q};
    y_ext    = {1'b0, y_q} + Y_STEP_E;
    cnt_inc  = cnt_q + 1'b1;
    step_due = (state_q == MARCH) && run && tick && (cnt_inc == period);
    edge_hit = dir_q ? (x_ext < X_LEFT_LIM_E) : ((x_ext + X_STEP_E) > X_MAX_E);
    x_d      = dir_q ? (x_q - X_STEP_R) : (x_q + X_STEP_R);
    y_d      = y_ext[Y_W-1:0];
    land_hit = (y_ext >= Y_LIMIT_E);
  end

`ifdef MARCH_SPEEDUP_EN
  logic [P_W-1:0] period_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= PERIOD_INIT_R;
    end else if (restart) begin
      period_q <= PERIOD_INIT_R;
    end else if (step_due && edge_hit && (period_q > P_W'(1))) begin
      period_q <= period_q - 1'b1;
    end
  end

  assign period = period_q;
`else
  assign period = PERIOD_INIT_R;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= X_MIN_R;
      y_q      <= Y_START_R;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      drop_q   <= 1'b0;
      landed_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      step_q <= 1'b0;
      drop_q <= 1'b0;
      // restart overrides everything, so a coincident tick is simply dropped.
      if (restart) begin
        state_q  <= IDLE;
        x_q      <= X_MIN_R;
        y_q      <= Y_START_R;
        dir_q    <= 1'b0;
        landed_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (run) state_q <= MARCH;
          end
          MARCH: begin
            if (run && tick) begin
              if (step_due) begin
                cnt_q <= '0;
                if (edge_hit) begin
                  y_q    <= y_d;
                  dir_q  <= ~dir_q;
                  drop_q <= 1'b1;
                  if (land_hit) begin
                    landed_q <= 1'b1;
                    state_q  <= LANDED;
                  end
                end else begin
                  x_q    <= x_d;
                  step_q <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_inc;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign dir_left   = dir_q;
  assign step_pulse = step_q;
  assign drop_pulse = drop_q;
  assign landed     = landed_q;

endmodule

// File: tb/tb_invader_march_ctrl.sv
// Scoreboard bench for invader_march_ctrl with a short period, narrow playfield and low landing line.
module tb_invader_march_ctrl;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       tick_in = 1'b0;
  logic       run     = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] x_pos;
  logic [8:0] y_pos;
  logic       dir_left, step_pulse, drop_pulse, landed;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

`ifdef MARCH_SPEEDUP_EN
  localparam int P2 = 3;
`else
  localparam int P2 = 4;
`endif

  invader_march_ctrl #(
    .PERIOD_INIT (4),
    .X_MAX       (24),
    .Y_LIMIT     (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_in    (tick_in),
    .run        (run),
    .restart    (restart),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .dir_left   (dir_left),
    .step_pulse (step_pulse),
    .drop_pulse (drop_pulse),
    .landed     (landed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit drop;
    int x;
    int y;
    bit dir;
    bit land;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;

  function automatic void cmp(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  // Monitor: every pulse must match the head of the scoreboard, on the predicted cycle.
  always @(negedge clk) begin
    if (!reset && (step_pulse || drop_pulse)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got step=%0d drop=%0d at cycle %0d, want none",
                 step_pulse, drop_pulse, cyc);
      end else begin
        m_e = sb.pop_front();
        cmp("pulse_kind", int'({step_pulse, drop_pulse}), m_e.drop ? 1 : 2);
        cmp("pulse_cycle", cyc, m_e.at);
        cmp("pulse_x", int'(x_pos), m_e.x);
        cmp("pulse_y", int'(y_pos), m_e.y);
        cmp("pulse_dir", int'(dir_left), int'(m_e.dir));
        cmp("pulse_landed", int'(landed), int'(m_e.land));
      end
    end else if (!reset && sb.size() > 0 && cyc > sb[0].at) begin
      m_e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missed_pulse: got no pulse by cycle %0d, want one at cycle %0d", cyc, m_e.at);
    end
  end

  task automatic send_tick(input bit ev, input bit drp, input int x, input int y,
                           input bit dir, input bit land);
    exp_t e;
    @(negedge clk);
    if (ev) begin
      e.drop = drp;
      e.x    = x;
      e.y    = y;
      e.dir  = dir;
      e.land = land;
      e.at   = cyc + 3;
      sb.push_back(e);
    end
    tick_in = 1'b1;
    repeat (2) @(negedge clk);
    tick_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) send_tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_outs(input string tag, input int x, input int y, input bit dir, input bit land);
    cmp({tag, "_x"}, int'(x_pos), x);
    cmp({tag, "_y"}, int'(y_pos), y);
    cmp({tag, "_dir"}, int'(dir_left), int'(dir));
    cmp({tag, "_landed"}, int'(landed), int'(land));
    cmp({tag, "_step"}, int'(step_pulse), 0);
    cmp({tag, "_drop"}, int'(drop_pulse), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by cycle %0d, want finish well before", cyc);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outs("reset", 8, 32, 1'b0, 1'b0);

    // Ticks before run must not advance anything.
    idle_ticks(2);
    run = 1'b1;
    @(negedge clk);

    idle_ticks(3);
    send_tick(1'b1, 1'b0, 16, 32, 1'b0, 1'b0);

    // Pause after 2 of 4 ticks; the count must resume where it stopped.
    idle_ticks(2);
    run = 1'b0;
    idle_ticks(5);
    check_outs("paused", 16, 32, 1'b0, 1'b0);
    run = 1'b1;
    idle_ticks(1);
    send_tick(1'b1, 1'b0, 24, 32, 1'b0, 1'b0);

    // Right edge: drop and turn.
    idle_ticks(3);
    send_tick(1'b1, 1'b1, 24, 48, 1'b1, 1'b0);

    // March left to X_MIN, then the left-edge drop reaches the landing line.
    idle_ticks(P2 - 1);
    send_tick(1'b1, 1'b0, 16, 48, 1'b1, 1'b0);
    idle_ticks(P2 - 1);
    send_tick(1'b1, 1'b0, 8, 48, 1'b1, 1'b0);
    idle_ticks(P2 - 1);
    send_tick(1'b1, 1'b1, 8, 64, 1'b0, 1'b1);

    idle_ticks(20);
    check_outs("landed_hold", 8, 64, 1'b0, 1'b1);

    // Restart lands in the same cycle as the detected tick.
    @(negedge clk);
    tick_in = 1'b1;
    repeat (2) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    tick_in = 1'b0;
    check_outs("restart", 8, 32, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    idle_ticks(3);
    send_tick(1'b1, 1'b0, 16, 32, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    cmp("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
